// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the ALU execution unit: opcodes, FSM states and
// datapath defaults.
package alu_exec_unit_pkg;

    localparam int unsigned DW_DEF   = 8;
    localparam int unsigned NREG_DEF = 8;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_AND   = 4'b0010;
    localparam logic [3:0] OP_OR    = 4'b0011;
    localparam logic [3:0] OP_XOR   = 4'b0100;
    localparam logic [3:0] OP_NOT   = 4'b0101;
    localparam logic [3:0] OP_SHL   = 4'b0110;
    localparam logic [3:0] OP_SHR   = 4'b0111;
    localparam logic [3:0] OP_ROL   = 4'b1000;
    localparam logic [3:0] OP_ROR   = 4'b1001;
    localparam logic [3:0] OP_INC   = 4'b1010;
    localparam logic [3:0] OP_DEC   = 4'b1011;
    localparam logic [3:0] OP_EQ    = 4'b1100;
    localparam logic [3:0] OP_LOADI = 4'b1111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        return op <= OP_EQ;
    endfunction

    // Only add and subtract update the architectural carry flag.
    function automatic logic sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_exec_unit_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// synchronous clear on reset.
module alu_regfile
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [$clog2(NREG)-1:0] ra1,
    input  logic [$clog2(NREG)-1:0] ra2,
    output logic [DW-1:0]           rd1,
    output logic [DW-1:0]           rd2,
    input  logic                    we,
    input  logic [$clog2(NREG)-1:0] wa,
    input  logic [DW-1:0]           wd
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

endmodule

// File: rtl/alu_exec_unit.sv
// Front-end / write-back stage around an external combinational ALU:
// accept, execute (ALU settles), write back with a one-cycle completion pulse.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int unsigned NREG = NREG_DEF,
    parameter int unsigned DW   = DW_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              in_op,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic [$clog2(NREG)-1:0] in_rs1,
    input  logic [$clog2(NREG)-1:0] in_rs2,
    input  logic [DW-1:0]           in_imm,
    output logic [3:0]              alu_ctrl,
    output logic [DW-1:0]           alu_x,
    output logic [DW-1:0]           alu_y,
    input  logic [DW-1:0]           alu_out,
    input  logic                    alu_carry,
    output logic                    out_valid,
    output logic [$clog2(NREG)-1:0] out_rd,
    output logic [DW-1:0]           out_data,
    output logic                    out_carry,
    output logic                    out_err
);

    localparam int unsigned AW = $clog2(NREG);

    state_t        state, state_nx;
    logic [3:0]    op_q;
    logic [AW-1:0] rd_q;
    logic [DW-1:0] imm_q;
    logic          carry_flag;
    logic [DW-1:0] rf_rd1, rf_rd2;
    logic          rf_we;
    logic [DW-1:0] rf_wd;
    logic          accept;
    logic          is_loadi;
    logic          legal;

    assign accept   = in_valid && in_ready;
    assign is_loadi = (op_q == OP_LOADI);
    assign legal    = is_alu_op(op_q) || is_loadi;
    assign rf_we    = (state == EXEC) && legal;
    assign rf_wd    = is_loadi ? imm_q : alu_out;

    alu_regfile #(
        .NREG (NREG),
        .DW   (DW)
    ) u_regfile (
        .clk (clk),
        .rst (rst),
        .ra1 (in_rs1),
        .ra2 (in_rs2),
        .rd1 (rf_rd1),
        .rd2 (rf_rd2),
        .we  (rf_we),
        .wa  (rd_q),
        .wd  (rf_wd)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = EXEC;
            EXEC:    state_nx = WB;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == WB);
    end

    // Reset has priority, so an instruction in flight is dropped without a write.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            alu_ctrl   <= '0;
            alu_x      <= '0;
            alu_y      <= '0;
            out_rd     <= '0;
            out_data   <= '0;
            out_err    <= 1'b0;
            carry_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q     <= in_op;
                        rd_q     <= in_rd;
                        imm_q    <= in_imm;
                        alu_ctrl <= in_op;
                        alu_x    <= rf_rd1;
                        alu_y    <= rf_rd2;
                    end
                end
                EXEC: begin
                    out_rd   <= rd_q;
                    out_err  <= !legal;
                    out_data <= legal ? rf_wd : '0;
                    if (sets_carry(op_q)) carry_flag <= alu_carry;
                end
                WB: out_err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign out_carry = carry_flag;

endmodule
